reg_bank: RTL

Parametrised memory-mapped register bank, successor to the fixed 4x32 register file behind the axi2reg bridge. It provides NUM_REGS registers, each DATA_W bits wide, with byte-lane write strobes and a registered read port with valid. Each register has a selectable mode: read-write (RW), read-only hardware status (RO), write-1-to-clear sticky status (W1C) or self-clearing pulse (PULSE). It sits between axi2reg and the user datapath.

---
 rtl/reg_bank.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/reg_bank.sv
`default_nettype none
// ============================================================================
//  Module   : reg_bank
//  Purpose  : Parametrised memory-mapped register bank. NUM_REGS registers of
//             DATA_W bits with byte-lane write strobes and a registered read
//             port. Each register is RW, RO (live hw_status), W1C (sticky,
//             set by hw_set) or PULSE (self-clearing after one cycle).
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst        : clock, synchronous active-high reset
//    reg_wren/wraddr/wrdata/wrstrb : write request (one per cycle)
//    reg_rden/rdaddr : read request, answered one cycle later
//    reg_rddata/rdvalid : registered read data and its qualifier
//    reg_wrerr       : one-cycle pulse on a write to RO / unmapped address
//    hw_status       : live values returned for RO registers
//    hw_set          : per-bit set requests for W1C registers
//    regs_out        : current value of every register
//    wr_pulse        : one-cycle strobe per register that accepted a write
// ============================================================================
module reg_bank #(
  parameter int                         NUM_REGS   = 8,
  parameter int                         ADDR_W     = 3,
  parameter int                         DATA_W     = 32,
  parameter logic [NUM_REGS-1:0]        RO_MASK    = '0,
  parameter logic [NUM_REGS-1:0]        W1C_MASK   = '0,
  parameter logic [NUM_REGS-1:0]        PULSE_MASK = '0,
  parameter logic [NUM_REGS*DATA_W-1:0] RESET_VAL  = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         reg_wren,
  input  logic [ADDR_W-1:0]            reg_wraddr,
  input  logic [DATA_W-1:0]            reg_wrdata,
  input  logic [DATA_W/8-1:0]          reg_wrstrb,
  input  logic                         reg_rden,
  input  logic [ADDR_W-1:0]            reg_rdaddr,
  output logic [DATA_W-1:0]            reg_rddata,
  output logic                         reg_rdvalid,
  output logic                         reg_wrerr,
  input  logic [NUM_REGS*DATA_W-1:0]   hw_status,
  input  logic [NUM_REGS*DATA_W-1:0]   hw_set,
  output logic [NUM_REGS*DATA_W-1:0]   regs_out,
  output logic [NUM_REGS-1:0]          wr_pulse
);

  localparam int c_NSTRB = DATA_W / 8;

  logic [DATA_W-1:0]   w_lanemask;
  logic [NUM_REGS-1:0] w_hit;
  logic [NUM_REGS-1:0] w_ro;
  logic [NUM_REGS-1:0] w_unused_status;
  logic [NUM_REGS-1:0] w_unused_set;
  logic                w_wr_ok;
  logic [DATA_W-1:0]   w_rd_val;

  logic [DATA_W-1:0]   r_rddata;
  logic                r_rdvalid;
  logic                r_wrerr;
  logic [NUM_REGS-1:0] r_wr_pulse;

  // Expand byte strobes into a per-bit mask.
  always_comb begin
    w_lanemask = '0;
    for (int b = 0; b < c_NSTRB; b++) begin
      w_lanemask[8*b +: 8] = {8{reg_wrstrb[b]}};
    end
  end

  generate
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
      localparam logic [DATA_W-1:0] c_RST      = RESET_VAL[i*DATA_W +: DATA_W];
      // Precedence when masks overlap: RO > W1C > PULSE > RW.
      localparam bit                c_IS_RO    = RO_MASK[i];
      localparam bit                c_IS_W1C   = W1C_MASK[i] && !RO_MASK[i];
      localparam bit                c_IS_PULSE = PULSE_MASK[i] && !W1C_MASK[i] && !RO_MASK[i];

      // An out-of-range address never matches any index, so it hits nothing.
      assign w_hit[i] = reg_wren && (reg_wraddr == ADDR_W'(i));
      assign w_ro[i]  = c_IS_RO;

      // Slices that a given mode does not consume are folded into sinks.
      assign w_unused_status[i] = ^hw_status[i*DATA_W +: DATA_W];
      assign w_unused_set[i]    = ^hw_set[i*DATA_W +: DATA_W];

      if (c_IS_RO) begin : g_ro
        assign regs_out[i*DATA_W +: DATA_W] = hw_status[i*DATA_W +: DATA_W];
      end else begin : g_stored
        logic [DATA_W-1:0] r_val;
        logic [DATA_W-1:0] w_next;

        always_comb begin
          w_next = r_val;
          if (c_IS_W1C) begin
            // OR-ing hw_set last makes a set win over a same-cycle clear.
            w_next = (r_val & ~(w_hit[i] ? (reg_wrdata & w_lanemask) : '0))
                   | hw_set[i*DATA_W +: DATA_W];
          end else if (c_IS_PULSE) begin
            // Unstrobed lanes show the idle value; any cycle without a
            // write returns the register to its idle value.
            w_next = w_hit[i] ? ((c_RST & ~w_lanemask) | (reg_wrdata & w_lanemask))
                              : c_RST;
          end else if (w_hit[i]) begin
            w_next = (r_val & ~w_lanemask) | (reg_wrdata & w_lanemask);
          end
        end

        always_ff @(posedge clk) begin
          if (rst) begin
            r_val <= c_RST;
          end else begin
            r_val <= w_next;
          end
        end

        assign regs_out[i*DATA_W +: DATA_W] = r_val;
      end
    end
  endgenerate

  assign w_wr_ok = |(w_hit & ~w_ro);

  // Read mux; unmapped addresses return zero.
  always_comb begin
    w_rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (reg_rdaddr == ADDR_W'(i)) begin
        w_rd_val = regs_out[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rddata   <= '0;
      r_rdvalid  <= 1'b0;
      r_wrerr    <= 1'b0;
      r_wr_pulse <= '0;
    end else begin
      r_rdvalid  <= reg_rden;
      if (reg_rden) begin
        r_rddata <= w_rd_val;
      end
      r_wrerr    <= reg_wren && !w_wr_ok;
      r_wr_pulse <= w_hit & ~w_ro;
    end
  end

  assign reg_rddata  = r_rddata;
  assign reg_rdvalid = r_rdvalid;
  assign reg_wrerr   = r_wrerr;
  assign wr_pulse    = r_wr_pulse;

endmodule
`default_nettype wire
